// File: rtl/utils_pkg.sv
// utils_pkg -- shared types and constants for the instruction assembler.
//   DATA_WIDTH : immediate width carried on the request stream (64).
//   enc_fmt_e  : request format (R, I, S, B, U, J and the LI pseudo-op).
//   OP_*       : opcodes that the LI expansion emits on its own.
//   fits_s*    : signed-fit tests used by the optional range check
//                (IMMENC_RANGE_CHECK_EN).
package utils_pkg;

  localparam int DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_B  = 3'd3,
    FMT_U  = 3'd4,
    FMT_J  = 3'd5,
    FMT_LI = 3'd6
  } enc_fmt_e;

  localparam logic [6:0] OP_ITY   = 7'h13;
  localparam logic [6:0] OP_I64TY = 7'h1b;
  localparam logic [6:0] OP_LUI   = 7'h37;

  // A value fits in N signed bits when every bit above N-1 equals bit N-1.
  function automatic logic fits_s12(input logic [DATA_WIDTH-1:0] v);
    return v == {{(DATA_WIDTH-12){v[11]}}, v[11:0]};
  endfunction

  function automatic logic fits_s13(input logic [DATA_WIDTH-1:0] v);
    return v == {{(DATA_WIDTH-13){v[12]}}, v[12:0]};
  endfunction

  function automatic logic fits_s21(input logic [DATA_WIDTH-1:0] v);
    return v == {{(DATA_WIDTH-21){v[20]}}, v[20:0]};
  endfunction

  function automatic logic fits_s32(input logic [DATA_WIDTH-1:0] v);
    return v == {{(DATA_WIDTH-32){v[31]}}, v[31:0]};
  endfunction

endpackage

// File: rtl/imm_scatter.sv
// imm_scatter -- combinational packing of instruction fields into a 32-bit
// RV64I word for the R, I, S, B, U and J layouts.
//   fmt                      : layout selector (anything else packs as R)
//   opcode, rd, rs1, rs2     : register/opcode fields
//   funct3, funct7           : function fields
//   imm                      : low 32 bits of the byte-offset immediate
//   word                     : packed instruction
module imm_scatter
  import utils_pkg::*;
(
  input  enc_fmt_e    fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] word
);

  always_comb begin
    word = {funct7, rs2, rs1, funct3, rd, opcode};
    case (fmt)
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      default: word = {funct7, rs2, rs1, funct3, rd, opcode};
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// imm_encoder -- instruction assembler: turns a decoded instruction
// description back into a 32-bit RV64I word, expanding the LI pseudo-op
// into ADDI, LUI or LUI+ADDIW.
//   clk_i, rst_i              : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o   : request handshake
//   fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i, funct7_i, imm_i : request
//   out_valid_o / out_ready_i : output handshake (single registered slot)
//   inst_o, last_o, err_o     : encoded word, last word of request, range error
// Optional feature: IMMENC_RANGE_CHECK_EN enables the immediate range check;
// without it err_o is constant 0.
module imm_encoder
  import utils_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  enc_fmt_e              fmt_i,
  input  logic [6:0]            opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [31:0]           inst_o,
  output logic                  last_o,
  output logic                  err_o
);

  typedef enum logic {ST_IDLE, ST_LI_LO} state_e;

  state_e      state_reg, state_next;
  logic        out_valid_reg;
  logic [31:0] inst_reg;
  logic        last_reg;
  logic [4:0]  li_rd_reg;
  logic [11:0] li_lo_reg;

  logic        slot_free;
  logic        load;
  logic        last_next;
  logic        li_save;
  logic [19:0] li_hi20;
  logic [11:0] li_lo12;
  logic        li_two_word;

  enc_fmt_e    sc_fmt;
  logic [6:0]  sc_opcode;
  logic [4:0]  sc_rd;
  logic [4:0]  sc_rs1;
  logic [2:0]  sc_funct3;
  logic [31:0] sc_imm;
  logic [31:0] sc_word;

  // The slot can take a new word when empty or being drained this cycle.
  assign slot_free = ~out_valid_reg | out_ready_i;

  // (imm + 0x800) >> 12 modulo 2^20: the +0x800 only carries into bit 12
  // when imm[11] is set, so the upper part is imm[31:12] + imm[11].
  assign li_hi20     = imm_i[31:12] + {19'd0, imm_i[11]};
  assign li_lo12     = imm_i[11:0];
  assign li_two_word = (fmt_i == FMT_LI) && (li_hi20 != 20'd0) && (li_lo12 != 12'd0);

  // Scatter inputs: the raw request, the first LI word, or the saved ADDIW.
  always_comb begin
    sc_fmt    = fmt_i;
    sc_opcode = opcode_i;
    sc_rd     = rd_i;
    sc_rs1    = rs1_i;
    sc_funct3 = funct3_i;
    sc_imm    = imm_i[31:0];
    if (state_reg == ST_LI_LO) begin
      sc_fmt    = FMT_I;
      sc_opcode = OP_I64TY;
      sc_rd     = li_rd_reg;
      sc_rs1    = li_rd_reg;
      sc_funct3 = 3'd0;
      sc_imm    = {20'd0, li_lo_reg};
    end else if (fmt_i == FMT_LI) begin
      sc_rs1    = 5'd0;
      sc_funct3 = 3'd0;
      if (li_hi20 == 20'd0) begin
        sc_fmt    = FMT_I;
        sc_opcode = OP_ITY;
        sc_imm    = {20'd0, li_lo12};
      end else begin
        sc_fmt    = FMT_U;
        sc_opcode = OP_LUI;
        sc_imm    = {li_hi20, 12'd0};
      end
    end
  end

  imm_scatter u_scatter (
    .fmt    (sc_fmt),
    .opcode (sc_opcode),
    .rd     (sc_rd),
    .rs1    (sc_rs1),
    .rs2    (rs2_i),
    .funct3 (sc_funct3),
    .funct7 (funct7_i),
    .imm    (sc_imm),
    .word   (sc_word)
  );

  // Next-state and slot-load control.
  always_comb begin
    state_next = state_reg;
    in_ready_o = 1'b0;
    load       = 1'b0;
    last_next  = 1'b1;
    li_save    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        in_ready_o = slot_free;
        if (in_valid_i && slot_free) begin
          load = 1'b1;
          if (li_two_word) begin
            last_next  = 1'b0;
            li_save    = 1'b1;
            state_next = ST_LI_LO;
          end
        end
      end
      ST_LI_LO: begin
        if (slot_free) begin
          load       = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      inst_reg      <= 32'd0;
      last_reg      <= 1'b0;
      li_rd_reg     <= 5'd0;
      li_lo_reg     <= 12'd0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        out_valid_reg <= 1'b1;
        inst_reg      <= sc_word;
        last_reg      <= last_next;
      end else if (out_ready_i) begin
        out_valid_reg <= 1'b0;
      end
      if (li_save) begin
        li_rd_reg <= rd_i;
        li_lo_reg <= li_lo12;
      end
    end
  end

  assign out_valid_o = out_valid_reg;
  assign inst_o      = inst_reg;
  assign last_o      = last_reg;

`ifdef IMMENC_RANGE_CHECK_EN
  logic err_in;
  logic err_reg;
  logic li_err_reg;

  always_comb begin
    err_in = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: err_in = ~fits_s12(imm_i);
      FMT_B:        err_in = ~fits_s13(imm_i) | imm_i[0];
      FMT_J:        err_in = ~fits_s21(imm_i) | imm_i[0];
      FMT_U:        err_in = (imm_i[11:0] != 12'd0) | ~fits_s32(imm_i);
      FMT_LI:       err_in = ~fits_s32(imm_i);
      default:      err_in = 1'b0;
    endcase
  end

  // The ADDIW word inherits the error flag of its originating LI request.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg    <= 1'b0;
      li_err_reg <= 1'b0;
    end else begin
      if (load) begin
        err_reg <= (state_reg == ST_LI_LO) ? li_err_reg : err_in;
      end
      if (li_save) begin
        li_err_reg <= err_in;
      end
    end
  end

  assign err_o = err_reg;
`else
  // Upper immediate bits only matter to the range check.
  logic imm_hi_unused;
  assign imm_hi_unused = ^imm_i[DATA_WIDTH-1:32];
  assign err_o         = 1'b0;
`endif

endmodule
